// File: rtl/incr_share_ctrl_pkg.sv
// Shared types and helpers for the shared-incrementer controller.
package incr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/incr_share_ctrl_if.sv
// Requester-side bus of the shared incrementer: requests and operands in, results out.
interface incr_share_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
) ();

  localparam int ID_W = incr_ctrl_pkg::id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         out;
  logic                     overflow;
  logic                     out_valid;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  modport master (
    output req, a_in,
    input  ack, out, overflow, out_valid, grant_id, busy
  );

  modport slave (
    input  req, a_in,
    output ack, out, overflow, out_valid, grant_id, busy
  );

endinterface

// File: rtl/incr_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
module rr_pick
  import incr_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W:0]   pos;
  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path can infer a latch.
    any_req = 1'b0;
    winner  = '0;
    pos     = '0;
    idx     = '0;
    // Walk from the farthest offset down so the nearest hit is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (pos >= (ID_W + 1)'(NUM_REQ)) pos = pos - (ID_W + 1)'(NUM_REQ);
      idx = pos[ID_W-1:0];
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/incr_share_ctrl.sv
// Time-shares one WIDTH-bit incrementer among NUM_REQ requesters with round-robin grants.
module incr_share_ctrl
  import incr_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int STEP    = 1
) (
  input logic             clk,
  input logic             rst_n,
  incr_share_ctrl_if.slave bus
);

  localparam int             ID_W     = id_width(NUM_REQ);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, grant_q, winner;
  logic            any_req;
  logic [WIDTH-1:0] op_sel, op_q, out_q;
  logic            ovf_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) op_sel = bus.a_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = COMPUTE;
      COMPUTE: state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      op_q     <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          op_q    <= op_sel;
          grant_q <= winner;
        end
        // Zero-extended add: the extra top bit is the carry-out.
        COMPUTE: {ovf_q, out_q} <= {1'b0, op_q} + STEP_EXT;
        RESPOND: rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == RESPOND) bus.ack[grant_q] = 1'b1;
  end

  assign bus.out_valid = (state_q == RESPOND);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_incr_share_ctrl.sv
// Self-checking bench for incr_share_ctrl: directed vectors, corner sequences, random vs. model.
module tb_incr_share_ctrl;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int STEP    = 1;
  localparam int AW      = NUM_REQ * WIDTH;
  localparam int BOUND   = 3 * NUM_REQ + 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  incr_share_ctrl_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  incr_share_ctrl #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // -1 when no bit set, -2 when more than one bit set.
  function automatic int ack_index(input logic [NUM_REQ-1:0] a);
    int idx = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (a[i]) idx = (idx == -1) ? i : -2;
    end
    return idx;
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int slice(input logic [AW-1:0] v, input int i);
    return int'(v[i*WIDTH +: WIDTH]);
  endfunction

  task automatic set_op(input int id, input int a);
    bus.a_in[id*WIDTH +: WIDTH] = WIDTH'(a);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Waits up to budget edges for an ack; id=-1 on timeout.
  task automatic wait_ack(input int budget, output int id, output int lat);
    id  = -1;
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack != '0) begin
        id  = ack_index(bus.ack);
        lat = c;
        return;
      end
    end
  endtask

  typedef struct {
    int id;
    int a;
    int exp_out;
    int exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int id, lat, exp_id, s;
    int model_ptr, last_out, last_ovf, aid;
    int waitcnt[NUM_REQ];
    logic [NUM_REQ-1:0] h0_req, h1_req;
    logic [AW-1:0]      h0_a, h1_a;

    tbl[0] = '{0,  7,  8, 0};
    tbl[1] = '{0, 15,  0, 1};
    tbl[2] = '{0, 14, 15, 0};
    tbl[3] = '{3,  9, 10, 0};
    tbl[4] = '{2,  0,  1, 0};
    tbl[5] = '{1, 12, 13, 0};

    // Reset state, sampled while reset is held.
    bus.req  = '0;
    bus.a_in = '0;
    #2;
    check("reset_ack",       int'(bus.ack), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out",       int'(bus.out), 0);
    check("reset_overflow",  int'(bus.overflow), 0);
    check("reset_grant_id",  int'(bus.grant_id), 0);
    check("reset_busy",      int'(bus.busy), 0);
    do_reset();

    // Directed single-requester vectors.
    foreach (tbl[i]) begin
      bus.a_in = AW'($urandom);
      set_op(tbl[i].id, tbl[i].a);
      bus.req = NUM_REQ'(1) << tbl[i].id;
      wait_ack(10, id, lat);
      check("vec_ack_id",    id, tbl[i].id);
      check("vec_latency",   lat, 2);
      check("vec_out",       int'(bus.out), tbl[i].exp_out);
      check("vec_overflow",  int'(bus.overflow), tbl[i].exp_ovf);
      check("vec_grant_id",  int'(bus.grant_id), tbl[i].id);
      check("vec_out_valid", int'(bus.out_valid), 1);
      bus.req = '0;
      @(posedge clk);
      #1;
      check("vec_ack_cleared", int'(bus.ack), 0);
      check("vec_idle_busy",   int'(bus.busy), 0);
    end

    // All four request together: served 0,1,2,3 after reset.
    do_reset();
    set_op(0, 0); set_op(1, 3); set_op(2, 14); set_op(3, 15);
    bus.req = 4'b1111;
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_ack(10, id, lat);
      check("all_order", id, k);
      s = slice(bus.a_in, k) + STEP;
      check("all_out",      int'(bus.out), s % (1 << WIDTH));
      check("all_overflow", int'(bus.overflow), (s >= (1 << WIDTH)) ? 1 : 0);
      if (id >= 0) bus.req[id] = 1'b0;
    end

    // req0 and req2 held continuously: grants alternate.
    do_reset();
    bus.a_in = AW'($urandom);
    bus.req  = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, id, lat);
      exp_id = (k % 2 == 0) ? 0 : 2;
      check("alt_order", id, exp_id);
      s = slice(bus.a_in, exp_id) + STEP;
      check("alt_out", int'(bus.out), s % (1 << WIDTH));
    end
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;

    // Operand captured at grant; dropping req during COMPUTE still gets an ack.
    do_reset();
    set_op(1, 5);
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    check("capture_busy", int'(bus.busy), 1);
    set_op(1, 9);
    bus.req = '0;
    wait_ack(10, id, lat);
    check("capture_ack_id", id, 1);
    check("capture_out",    int'(bus.out), 6);
    check("capture_ovf",    int'(bus.overflow), 0);
    @(posedge clk);
    #1;

    // Reset during COMPUTE drops the transaction and clears outputs and rr_ptr.
    do_reset();
    set_op(2, 4);
    bus.req = 4'b0100;
    wait_ack(10, id, lat);
    check("rst_pre_id", id, 2);
    bus.req = '0;
    @(posedge clk);
    #1;
    set_op(0, 10);
    bus.req = 4'b0001;
    @(posedge clk);
    #1;
    check("rst_pre_busy", int'(bus.busy), 1);
    check("rst_pre_out",  int'(bus.out), 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack",       int'(bus.ack), 0);
    check("rst_mid_out_valid", int'(bus.out_valid), 0);
    check("rst_mid_out",       int'(bus.out), 0);
    check("rst_mid_busy",      int'(bus.busy), 0);
    check("rst_mid_grant_id",  int'(bus.grant_id), 0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_post_ack", int'(bus.ack), 0);
    set_op(1, 6); set_op(3, 2);
    bus.req = 4'b1010;
    wait_ack(10, id, lat);
    check("rst_post_first", id, 1);
    check("rst_post_lat",   lat, 2);
    check("rst_post_out",   int'(bus.out), 7);
    bus.req[1] = 1'b0;
    wait_ack(10, id, lat);
    check("rst_post_second", id, 3);
    check("rst_post_out2",   int'(bus.out), 3);
    bus.req = '0;

    // Random clients against the rule-level model.
    do_reset();
    model_ptr = 0;
    last_out  = 0;
    last_ovf  = 0;
    h0_req = '0; h1_req = '0; h0_a = '0; h1_a = '0;
    foreach (waitcnt[i]) waitcnt[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      h1_req = h0_req; h1_a = h0_a;
      h0_req = bus.req; h0_a = bus.a_in;
      #1;
      aid = ack_index(bus.ack);
      check("rand_ack_onehot", (aid == -2) ? 1 : 0, 0);
      check("rand_valid_vs_ack", int'(bus.out_valid), (bus.ack != '0) ? 1 : 0);
      if (aid >= 0) begin
        exp_id = model_pick(h1_req, model_ptr);
        check("rand_winner",   aid, exp_id);
        check("rand_grant_id", int'(bus.grant_id), aid);
        s = slice(h1_a, aid) + STEP;
        check("rand_out",      int'(bus.out), s % (1 << WIDTH));
        check("rand_overflow", int'(bus.overflow), (s >= (1 << WIDTH)) ? 1 : 0);
        model_ptr    = (aid + 1) % NUM_REQ;
        last_out     = s % (1 << WIDTH);
        last_ovf     = (s >= (1 << WIDTH)) ? 1 : 0;
        bus.req[aid] = 1'b0;
        waitcnt[aid] = 0;
      end else begin
        check("rand_out_hold", int'(bus.out), last_out);
        check("rand_ovf_hold", int'(bus.overflow), last_ovf);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i]) begin
          waitcnt[i]++;
          if (waitcnt[i] > BOUND) begin
            check("rand_starvation", waitcnt[i], BOUND);
            waitcnt[i] = 0;
          end
        end else if (i != aid && $urandom_range(3) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      bus.a_in = AW'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
